aec_feeder: RTL

AEC_FEEDER -- requirements
Module: aec_feeder

---
 rtl/aec_feeder_if.sv | 20 ++
 rtl/aec_feeder.sv | 126 ++++++++++++
 2 files changed

// File: rtl/aec_feeder_if.sv
// Host-byte and evaluator handshake bundle for aec_feeder.
// master: host/evaluator side; slave: the feeder itself.
interface aec_feeder_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       aec_ready;
  logic [7:0] aec_ascii;
  logic       aec_valid;

  modport master (
    output in_valid, in_data, aec_valid,
    input  in_ready, aec_ready, aec_ascii
  );

  modport slave (
    input  in_valid, in_data, aec_valid,
    output in_ready, aec_ready, aec_ascii
  );
endinterface

// File: rtl/aec_feeder.sv
// Collects a filtered ASCII expression and replays it, '='-terminated, to an evaluator.
// Optional FEEDER_CASE_FOLD_EN: accept 'A'-'F' and store them as 'a'-'f'.
module aec_feeder (
  input  logic              clk,
  input  logic              rst,
  aec_feeder_if.slave       bus,
  output logic              busy,
  output logic              err,
  output logic [4:0]        expr_len
);

  typedef enum logic [1:0] {StCollect, StDrop, StPlay, StWait} state_e;

  localparam logic [7:0] ChEq    = 8'd61;
  localparam logic [7:0] ChSpace = 8'd32;

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] idx_q, idx_d;
  logic [4:0] len_q, len_d;
  logic       err_q, err_d;
  logic       live_q;
  logic [7:0] buf_q [16];
  logic       buf_we;
  logic [7:0] byte_c;
  logic       legal_c;
  logic       in_ready_c;
  logic       accept_c;

  always_comb begin
    byte_c = bus.in_data;
`ifdef FEEDER_CASE_FOLD_EN
    if (bus.in_data >= 8'd65 && bus.in_data <= 8'd70) byte_c = bus.in_data + 8'd32;
`endif
  end

  assign legal_c = (byte_c >= 8'd48 && byte_c <= 8'd57) ||
                   (byte_c >= 8'd97 && byte_c <= 8'd102) ||
                   (byte_c >= 8'd40 && byte_c <= 8'd43) ||
                   (byte_c == 8'd45);

  // live_q holds in_ready low until the first edge after reset release.
  assign in_ready_c = live_q && (state_q == StCollect || state_q == StDrop);
  assign accept_c   = bus.in_valid && in_ready_c;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    len_d   = len_q;
    err_d   = 1'b0;
    buf_we  = 1'b0;
    unique case (state_q)
      StCollect: begin
        if (accept_c) begin
          if (bus.in_data == ChEq) begin
            if (cnt_q != 5'd0) begin
              state_d = StPlay;
              idx_d   = 5'd0;
              len_d   = cnt_q;
              cnt_d   = 5'd0;
            end
          end else if (bus.in_data == ChSpace) begin
            cnt_d = cnt_q;
          end else if (legal_c && cnt_q != 5'd16) begin
            buf_we = 1'b1;
            cnt_d  = cnt_q + 5'd1;
          end else begin
            err_d   = 1'b1;
            cnt_d   = 5'd0;
            state_d = StDrop;
          end
        end
      end
      StDrop: begin
        if (accept_c && bus.in_data == ChEq) begin
          state_d = StCollect;
          cnt_d   = 5'd0;
        end
      end
      StPlay: begin
        // idx_q == len_q is the terminator slot.
        if (idx_q == len_q) state_d = StWait;
        else                idx_d   = idx_q + 5'd1;
      end
      StWait: begin
        if (bus.aec_valid) begin
          state_d = StCollect;
          cnt_d   = 5'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StCollect;
      cnt_q   <= 5'd0;
      idx_q   <= 5'd0;
      len_q   <= 5'd0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
    end
  end

  // Character storage needs no reset; an abandoned expression is never replayed.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[cnt_q[3:0]] <= byte_c;
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.aec_ready = (state_q == StPlay) && (idx_q == 5'd0);
  assign bus.aec_ascii = (state_q != StPlay) ? 8'h00 :
                         (idx_q == len_q)    ? ChEq  : buf_q[idx_q[3:0]];
  assign busy          = (state_q == StPlay) || (state_q == StWait);
  assign err           = err_q;
  assign expr_len      = len_q;

endmodule
